conv_ctrl: RTL and testbench
============================

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter n, default 28, input feature map width/height.
REQ-002 SHALL have parameter k, default 5, convolver kernel size; M = n-k+1 output width/height.
REQ-003 SHALL have parameter N, default 16, pixel/result bit width.
REQ-004 SHALL have parameter TMO, default 16, cycles allowed for conv_done_i to respond.
REQ-005 SHALL have ports: clk_i  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have ports: rst_i  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: start_i  in  1 (start job, sampled in IDLE); abort_i  in  1 (cancel job).
REQ-008 SHALL have ports: busy_o  out  1; done_o  out  1 (one-cycle completion pulse); err_o  out  1 (sticky timeout flag).
REQ-009 SHALL have ports: pix_rd_o  out  1; pix_addr_o  out  clog2(n*n); pix_data_i  in  N (read data 1 cycle after pix_rd_o).
REQ-010 SHALL have ports: conv_en_o  out  1; conv_rst_o  out  1; conv_act_o  out  N; conv_data_i  in  N signed; conv_done_i  in  1.
REQ-011 SHALL have ports: out_we_o  out  1; out_addr_o  out  clog2(M*M); out_data_o  out  N.

Function
REQ-012 SHALL implement states IDLE, STREAM, DRAIN, WAIT_CDONE, RELEASE, DONE.
REQ-013 IDLE: busy_o=0; start_i=1 -> STREAM, read counter rc=0, write counter wc=0, err_o cleared; start_i ignored in all other states.
REQ-014 STREAM: pix_rd_o=1, pix_addr_o=rc, rc+1 per cycle, conv_en_o=1; after issuing rc=n*n-1 -> DRAIN.
REQ-015 conv_act_o SHALL equal pix_data_i combinationally (convolver samples it one cycle after each read issue).
REQ-016 Controller SHALL track (row, col) of each pixel delayed 2 cycles from read issue (cycle conv_data_i reflects it); qualify when row>=k-1 and col>=k-1.
REQ-017 On qualification, next cycle: out_we_o=1, out_data_o=registered conv_data_i, out_addr_o=wc, wc+1; exactly M*M writes per job, addresses 0..M*M-1 raster order.
REQ-018 Let t0 = first STREAM cycle; write for pixel p occurs at t(p+3); first write t((k-1)*n+k+2), last write t(n*n+2).
REQ-019 DRAIN: pix_rd_o=0, conv_en_o=1; after last write (wc reaches M*M) -> WAIT_CDONE.
REQ-020 WAIT_CDONE: conv_en_o=1; conv_done_i=1 -> RELEASE; TMO cycles without it -> err_o=1, conv_rst_o pulse 1 cycle, -> IDLE, no done_o.
REQ-021 RELEASE: conv_en_o=0; conv_done_i=0 -> DONE; same TMO timeout rule as REQ-020.
REQ-022 DONE: done_o=1 for exactly one cycle, -> IDLE; start_i in that cycle ignored.
REQ-023 busy_o=1 in every state except IDLE.
REQ-024 abort_i=1 in any non-IDLE state: next cycle IDLE, conv_en_o=0, conv_rst_o=1 for one cycle, no further writes or reads, no done_o; abort_i has priority over every other transition; abort_i in IDLE ignored.
REQ-025 out_we_o, pix_rd_o SHALL never assert outside STREAM/DRAIN (pix_rd_o STREAM only).
REQ-026 Counters SHALL not wrap within a job; rc, wc sized to hold n*n-1, M*M.

Reset
REQ-027 rst_i=1 at a clock edge: state IDLE, rc=wc=0, delay pipeline cleared, busy_o=done_o=err_o=pix_rd_o=conv_en_o=out_we_o=0, out_addr_o=out_data_o=pix_addr_o=0.
REQ-028 conv_rst_o SHALL be 1 while rst_i=1 (rst_i OR internal pulse); reset mid-job discards the job with no done_o and no further writes.

Verification
REQ-029 n=6,k=3, ramp image pix=addr, all-ones-at-centre kernel: start_i pulse -> reads 0..35 at t0..t35, 16 writes at t17..t38, out_data equals pixel (r+1,c+1), done_o 1 cycle after conv_done_i falls.
REQ-030 abort_i at t10 -> conv_rst_o=1 at t11, state IDLE, zero writes, done_o never asserted; new start completes normally.
REQ-031 conv_done_i held 0 in WAIT_CDONE -> after 16 cycles err_o=1, conv_rst_o pulse, busy_o=0, no done_o.
REQ-032 start_i held high for whole job -> exactly one job (36 reads, 16 writes, one done_o); start_i in DONE cycle not accepted.
REQ-033 rst_i asserted at t20 for 1 cycle -> all outputs 0 next cycle, conv_rst_o=1 during rst_i, no writes after t20.
REQ-034 n=5,k=5 (M=1): exactly one write at address 0 at t27.

Source files
------------

// File: rtl/conv_ctrl.sv
// conv_ctrl: streams an n x n feature map into a convolver and stores the M x M valid results.
module conv_ctrl #(
    parameter  int unsigned n   = 28,
    parameter  int unsigned k   = 5,
    parameter  int unsigned N   = 16,
    parameter  int unsigned TMO = 16,
    localparam int unsigned M   = n - k + 1,
    localparam int unsigned NN  = n * n,
    localparam int unsigned MM  = M * M,
    localparam int unsigned PAW = (NN > 1) ? $clog2(NN) : 1,
    localparam int unsigned OAW = (MM > 1) ? $clog2(MM) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                pix_rd_o,
    output logic [PAW-1:0]      pix_addr_o,
    input  logic [N-1:0]        pix_data_i,
    output logic                conv_en_o,
    output logic                conv_rst_o,
    output logic [N-1:0]        conv_act_o,
    input  logic signed [N-1:0] conv_data_i,
    input  logic                conv_done_i,
    output logic                out_we_o,
    output logic [OAW-1:0]      out_addr_o,
    output logic [N-1:0]        out_data_o
);

    localparam int unsigned WCW = $clog2(MM + 1);
    localparam int unsigned CW  = (n > 1) ? $clog2(n) : 1;
    localparam int unsigned TW  = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        WAIT_CDONE,
        RELEASE,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic            abort_hit;
    logic            tmo_hit;
    logic            qual;
    logic            conv_rst_q;
    logic [WCW-1:0]  wc_q;
    logic [TW-1:0]   tmr_q;
    logic [CW-1:0]   row_q, col_q;
    logic [CW-1:0]   s1_row_q, s1_col_q, s2_row_q, s2_col_q;
    logic            s1_v_q, s2_v_q;

    // The convolver samples read data directly in the cycle after each read issue.
    assign conv_act_o = pix_data_i;
    assign conv_rst_o = rst_i | conv_rst_q;

    // A pixel two cycles past its read issue lines up with conv_data_i; keep it if its window is complete.
    assign qual = s2_v_q && ((state_q == STREAM) || (state_q == DRAIN)) &&
                  (s2_row_q >= CW'(k - 1)) && (s2_col_q >= CW'(k - 1));

    // Next-state logic; abort from any active state overrides every other transition.
    always_comb begin
        state_d   = state_q;
        abort_hit = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state_q)
            IDLE:       if (start_i) state_d = STREAM;
            STREAM:     if (pix_addr_o == PAW'(NN - 1)) state_d = DRAIN;
            DRAIN:      if (wc_q == WCW'(MM)) state_d = WAIT_CDONE;
            WAIT_CDONE: begin
                if (conv_done_i) begin
                    state_d = RELEASE;
                end else if (tmr_q == TW'(TMO - 1)) begin
                    state_d = IDLE;
                    tmo_hit = 1'b1;
                end
            end
            RELEASE: begin
                if (!conv_done_i) begin
                    state_d = DONE;
                end else if (tmr_q == TW'(TMO - 1)) begin
                    state_d = IDLE;
                    tmo_hit = 1'b1;
                end
            end
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if ((state_q != IDLE) && abort_i) begin
            state_d   = IDLE;
            abort_hit = 1'b1;
            tmo_hit   = 1'b0;
        end
    end

    // State register, handshake timer and status outputs registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            pix_rd_o   <= 1'b0;
            conv_en_o  <= 1'b0;
            conv_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_o     <= (state_d != IDLE);
            done_o     <= (state_d == DONE);
            pix_rd_o   <= (state_d == STREAM);
            conv_en_o  <= (state_d == STREAM) || (state_d == DRAIN) || (state_d == WAIT_CDONE);
            conv_rst_q <= abort_hit || tmo_hit;
            if (state_d != state_q) begin
                tmr_q <= '0;
            end else if ((state_q == WAIT_CDONE) || (state_q == RELEASE)) begin
                tmr_q <= tmr_q + TW'(1);
            end
            if ((state_q == IDLE) && start_i) begin
                err_o <= 1'b0;
            end else if (tmo_hit) begin
                err_o <= 1'b1;
            end
        end
    end

    // Read address / raster position, coordinate delay pipeline and result write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_addr_o <= '0;
            row_q      <= '0;
            col_q      <= '0;
            s1_v_q     <= 1'b0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_row_q   <= '0;
            s2_col_q   <= '0;
            wc_q       <= '0;
            out_we_o   <= 1'b0;
            out_addr_o <= '0;
            out_data_o <= '0;
        end else begin
            if ((state_q == IDLE) && start_i) begin
                pix_addr_o <= '0;
                row_q      <= '0;
                col_q      <= '0;
                wc_q       <= '0;
            end else if ((state_q == STREAM) && (state_d == STREAM)) begin
                pix_addr_o <= pix_addr_o + PAW'(1);
                if (col_q == CW'(n - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            s1_v_q   <= (state_q == STREAM) && !abort_hit;
            s1_row_q <= row_q;
            s1_col_q <= col_q;
            s2_v_q   <= s1_v_q && !abort_hit;
            s2_row_q <= s1_row_q;
            s2_col_q <= s1_col_q;
            out_we_o <= qual && !abort_hit;
            if (qual && !abort_hit) begin
                out_data_o <= $unsigned(conv_data_i);
                out_addr_o <= OAW'(wc_q);
                wc_q       <= wc_q + WCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: random-image jobs against a frame-level model of the expected read/write schedule.
module tb_conv_ctrl;

    localparam int NA  = 6;
    localparam int KA  = 3;
    localparam int MA  = NA - KA + 1;
    localparam int NNA = NA * NA;
    localparam int MMA = MA * MA;
    localparam int TMO = 16;
    localparam int NB  = 5;
    localparam int KB  = 5;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // DUT A: n=6, k=3
    logic               rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
    logic               busy_o, done_o, err_o, pix_rd_o;
    logic [5:0]         pix_addr_o;
    logic [15:0]        pix_data_i = '0;
    logic               conv_en_o, conv_rst_o;
    logic [15:0]        conv_act_o;
    logic signed [15:0] conv_data_i = '0;
    logic               conv_done_i = 1'b0;
    logic               out_we_o;
    logic [3:0]         out_addr_o;
    logic [15:0]        out_data_o;

    conv_ctrl #(.n(NA), .k(KA), .N(16), .TMO(TMO)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .pix_rd_o(pix_rd_o), .pix_addr_o(pix_addr_o), .pix_data_i(pix_data_i),
        .conv_en_o(conv_en_o), .conv_rst_o(conv_rst_o), .conv_act_o(conv_act_o),
        .conv_data_i(conv_data_i), .conv_done_i(conv_done_i),
        .out_we_o(out_we_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o)
    );

    // DUT B: n=5, k=5 (single output)
    logic               rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0;
    logic               busy_b, done_b, err_b, pix_rd_b;
    logic [4:0]         pix_addr_b;
    logic [15:0]        pix_data_b = '0;
    logic               conv_en_b, conv_rst_b;
    logic [15:0]        conv_act_b;
    logic signed [15:0] conv_data_b;
    logic               conv_done_b = 1'b0;
    logic               out_we_b;
    logic [0:0]         out_addr_b;
    logic [15:0]        out_data_b;

    assign conv_data_b = $signed(16'(cyc));

    conv_ctrl #(.n(NB), .k(KB), .N(16), .TMO(TMO)) u_dut_b (
        .clk_i(clk_i), .rst_i(rst_b), .start_i(start_b), .abort_i(abort_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
        .pix_rd_o(pix_rd_b), .pix_addr_o(pix_addr_b), .pix_data_i(pix_data_b),
        .conv_en_o(conv_en_b), .conv_rst_o(conv_rst_b), .conv_act_o(conv_act_b),
        .conv_data_i(conv_data_b), .conv_done_i(conv_done_b),
        .out_we_o(out_we_b), .out_addr_o(out_addr_b), .out_data_o(out_data_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pixel memory: one-cycle read latency
    logic [15:0] img [NNA];
    always @(posedge clk_i) if (pix_rd_o) pix_data_i <= img[pix_addr_o];

    // Convolver stand-in with a 3x3 kernel that is 1 at the centre: output = window centre pixel
    logic [15:0] hist[$];
    logic        rd_d1 = 1'b0;
    always @(posedge clk_i) begin
        rd_d1 <= pix_rd_o;
        if (!busy_o) begin
            hist.delete();
        end else if (rd_d1) begin
            hist.push_back(conv_act_o);
            if (hist.size() > NA + 1) conv_data_i <= $signed(hist[hist.size() - 1 - (NA + 1)]);
        end
    end

    // Bus monitors
    int rd_cyc[$], rd_adr[$], wr_cyc[$], wr_adr[$], wr_dat[$], dn_cyc[$];
    int bw_cyc[$], bw_adr[$], bw_dat[$], bd_cyc[$];
    always @(negedge clk_i) begin
        if (pix_rd_o) begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(pix_addr_o)); end
        if (out_we_o) begin
            wr_cyc.push_back(cyc); wr_adr.push_back(int'(out_addr_o)); wr_dat.push_back(int'(out_data_o));
        end
        if (done_o) dn_cyc.push_back(cyc);
        if (out_we_b) begin
            bw_cyc.push_back(cyc); bw_adr.push_back(int'(out_addr_b)); bw_dat.push_back(int'(out_data_b));
        end
        if (done_b) bd_cyc.push_back(cyc);
    end

    // DUT B convolver handshake: done once its result is written, drop when enable falls
    logic b_wrote = 1'b0;
    always @(posedge clk_i) begin
        if (!busy_b) b_wrote <= 1'b0;
        else if (out_we_b) b_wrote <= 1'b1;
        conv_done_b <= b_wrote && conv_en_b;
    end

    task automatic run_job(input int abort_at, input int rst_at, input bit hold_start,
                           input bit no_cdone, input bit ramp);
        int t0, rel, rb, wb, db, cd_wait, rl_wait, drop_cyc, lim, n_rd, bad, nexp;
        int e_cyc[$], e_adr[$], e_dat[$];
        bit fin, raised, normal;
        normal = (abort_at < 0) && (rst_at < 0) && !no_cdone;
        for (int i = 0; i < NNA; i++) img[i] = ramp ? 16'(i) : 16'($urandom);
        rb = rd_cyc.size(); wb = wr_cyc.size(); db = dn_cyc.size();
        @(negedge clk_i); #1;
        start_i  = 1'b1;
        t0       = cyc + 1;
        cd_wait  = int'($urandom_range(1, 6));
        rl_wait  = int'($urandom_range(0, 3));
        fin = 1'b0; raised = 1'b0; drop_cyc = -1;
        for (int step = 0; step < 300 && !fin; step++) begin
            @(negedge clk_i); #1;
            rel = cyc - t0;
            if (!hold_start) start_i = 1'b0;
            if (hold_start && done_o) start_i = 1'b0;
            abort_i = 1'b0;
            if (rel == 0) begin
                check_eq("t0_busy", 32'(busy_o), 1);
                check_eq("t0_pix_rd", 32'(pix_rd_o), 1);
                check_eq("t0_conv_en", 32'(conv_en_o), 1);
                check_eq("t0_err_clr", 32'(err_o), 0);
            end
            if (abort_at >= 0) begin
                if (rel == abort_at) abort_i = 1'b1;
                if (rel == abort_at + 1) begin
                    check_eq("abort_conv_rst", 32'(conv_rst_o), 1);
                    check_eq("abort_busy", 32'(busy_o), 0);
                    check_eq("abort_conv_en", 32'(conv_en_o), 0);
                end
                if (rel == abort_at + 2) check_eq("abort_rst_pulse", 32'(conv_rst_o), 0);
                if (rel == abort_at + 40) fin = 1'b1;
            end else if (rst_at >= 0) begin
                if (rel == rst_at) begin
                    rst_i = 1'b1; #1;
                    check_eq("rst_conv_rst", 32'(conv_rst_o), 1);
                end
                if (rel == rst_at + 1) begin
                    check_eq("rst_busy", 32'(busy_o), 0);
                    check_eq("rst_done", 32'(done_o), 0);
                    check_eq("rst_err", 32'(err_o), 0);
                    check_eq("rst_pix_rd", 32'(pix_rd_o), 0);
                    check_eq("rst_conv_en", 32'(conv_en_o), 0);
                    check_eq("rst_out_we", 32'(out_we_o), 0);
                    check_eq("rst_out_addr", 32'(out_addr_o), 0);
                    check_eq("rst_out_data", 32'(out_data_o), 0);
                    check_eq("rst_pix_addr", 32'(pix_addr_o), 0);
                    rst_i = 1'b0; #1;
                    check_eq("rst_release", 32'(conv_rst_o), 0);
                end
                if (rel == rst_at + 40) fin = 1'b1;
            end else if (no_cdone) begin
                if (rel == NNA + 2 + TMO) begin
                    check_eq("tmo_pre_busy", 32'(busy_o), 1);
                    check_eq("tmo_pre_err", 32'(err_o), 0);
                end
                if (rel == NNA + 3 + TMO) begin
                    check_eq("tmo_err", 32'(err_o), 1);
                    check_eq("tmo_conv_rst", 32'(conv_rst_o), 1);
                    check_eq("tmo_busy", 32'(busy_o), 0);
                end
                if (rel == NNA + 4 + TMO) begin
                    check_eq("tmo_err_sticky", 32'(err_o), 1);
                    check_eq("tmo_rst_pulse", 32'(conv_rst_o), 0);
                    fin = 1'b1;
                end
            end else begin
                if (!raised && (wr_cyc.size() - wb == MMA)) begin
                    if (cd_wait == 0) begin conv_done_i = 1'b1; raised = 1'b1; end
                    else cd_wait--;
                end
                if (raised && drop_cyc < 0 && !conv_en_o) begin
                    if (rl_wait == 0) begin conv_done_i = 1'b0; drop_cyc = cyc; end
                    else rl_wait--;
                end
                if (drop_cyc >= 0 && cyc == drop_cyc + 2) begin
                    check_eq("post_done_busy", 32'(busy_o), 0);
                    check_eq("done_one_cycle", 32'(done_o), 0);
                    fin = 1'b1;
                end
            end
        end
        start_i = 1'b0; abort_i = 1'b0; conv_done_i = 1'b0; rst_i = 1'b0;
        check_eq("job_budget", 32'(fin), 1);

        // Reads: one per cycle from t0, raster addresses, cut short by abort/reset
        nexp = (abort_at >= 0) ? abort_at + 1 : (rst_at >= 0) ? rst_at + 1 : NNA;
        n_rd = rd_cyc.size() - rb;
        check_eq("rd_count", 32'(n_rd), 32'(nexp));
        bad = 0;
        for (int i = 0; i < n_rd && i < nexp; i++)
            if (rd_cyc[rb + i] != t0 + i || rd_adr[rb + i] != i) bad++;
        check_eq("rd_sequence", 32'(bad), 0);

        // Writes: output (r,c) equals window centre pixel (r+1,c+1), issued 3 cycles after its last pixel
        lim = (abort_at >= 0) ? abort_at : (rst_at >= 0) ? rst_at : -1;
        for (int p = 0; p < NNA; p++) begin
            int row, col;
            row = p / NA; col = p % NA;
            if (row >= KA - 1 && col >= KA - 1 && (lim < 0 || p + 3 <= lim)) begin
                e_cyc.push_back(t0 + p + 3);
                e_adr.push_back((row - KA + 1) * MA + (col - KA + 1));
                e_dat.push_back(int'(img[(row - KA + 2) * NA + (col - KA + 2)]));
            end
        end
        check_eq("wr_count", 32'(wr_cyc.size() - wb), 32'(e_cyc.size()));
        for (int i = 0; i < e_cyc.size() && wb + i < wr_cyc.size(); i++) begin
            check_eq($sformatf("wr%0d_cycle", i), 32'(wr_cyc[wb + i] - t0), 32'(e_cyc[i] - t0));
            check_eq($sformatf("wr%0d_addr", i), 32'(wr_adr[wb + i]), 32'(e_adr[i]));
            check_eq($sformatf("wr%0d_data", i), 32'(wr_dat[wb + i]), 32'(e_dat[i]));
        end

        check_eq("done_count", 32'(dn_cyc.size() - db), normal ? 1 : 0);
        if (normal && dn_cyc.size() > db)
            check_eq("done_timing", 32'(dn_cyc[db] - drop_cyc), 1);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        int tb0;
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("reset_conv_rst", 32'(conv_rst_o), 1);
        check_eq("reset_busy", 32'(busy_o), 0);
        check_eq("reset_pix_addr", 32'(pix_addr_o), 0);
        check_eq("reset_out_we", 32'(out_we_o), 0);
        rst_i = 1'b0; rst_b = 1'b0;
        #1;
        check_eq("reset_release", 32'(conv_rst_o), 0);

        run_job(-1, -1, 1'b0, 1'b0, 1'b1);   // ramp image
        run_job(-1, -1, 1'b0, 1'b0, 1'b0);
        run_job(10, -1, 1'b0, 1'b0, 1'b0);   // abort at t10
        run_job(-1, -1, 1'b0, 1'b0, 1'b0);
        run_job(-1, -1, 1'b0, 1'b1, 1'b0);   // convolver never completes
        run_job(-1, -1, 1'b0, 1'b0, 1'b0);
        run_job(-1, -1, 1'b1, 1'b0, 1'b0);   // start held through the job
        run_job(-1, 20, 1'b0, 1'b0, 1'b0);   // reset at t20
        run_job(-1, -1, 1'b0, 1'b0, 1'b0);

        // Single-output configuration
        @(negedge clk_i); #1;
        start_b = 1'b1;
        tb0 = cyc + 1;
        @(negedge clk_i); #1;
        start_b = 1'b0;
        for (int i = 0; i < 150 && bd_cyc.size() == 0; i++) @(negedge clk_i);
        #1;
        check_eq("b_done_count", 32'(bd_cyc.size()), 1);
        check_eq("b_wr_count", 32'(bw_cyc.size()), 1);
        check_eq("b_wr_addr", (bw_adr.size() > 0) ? 32'(bw_adr[0]) : 32'hFFFF_FFFF, 0);
        check_eq("b_wr_cycle", (bw_cyc.size() > 0) ? 32'(bw_cyc[0] - tb0) : 32'hFFFF_FFFF, 27);
        check_eq("b_wr_data", (bw_cyc.size() > 0) ? 32'(bw_dat[0]) : 32'hFFFF_FFFF,
                 (bw_cyc.size() > 0) ? 32'(16'(bw_cyc[0] - 1)) : 32'd0);
        check_eq("b_err", 32'(err_b), 0);
        check_eq("b_busy_end", 32'(busy_b), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
